// File: rtl/si_stats_window_ctrl_pkg.sv
// Shared definitions for the statistics window controller: FSM states,
// snapshot/overrun widths and the window reload helper.
package si_stats_window_ctrl_pkg;

   localparam int SEQ_W = 8;
   localparam int OVR_W = 16;
   localparam int WIN_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // A programmed length of zero behaves as a one-cycle window.
   function automatic logic [WIN_W-1:0] window_reload(input logic [WIN_W-1:0] len);
      return (len == '0) ? '0 : len - 1'b1;
   endfunction

endpackage

// File: rtl/si_stats_window_ctrl_timer.sv
// Loadable window down-counter; expire is high while the count sits at zero.
module si_stats_window_timer
   import si_stats_window_ctrl_pkg::*;
#(
   parameter logic [WIN_W-1:0] RESET_VALUE = '1
) (
   input  logic             eth_clk,
   input  logic             eth_rst,
   input  logic             load,
   input  logic             enable,
   input  logic [WIN_W-1:0] value,
   output logic             expire
);

   logic [WIN_W-1:0] count;

   always_ff @(posedge eth_clk) begin
      if (eth_rst) begin
         count <= RESET_VALUE;
      end else if (load) begin
         count <= value;
      end else if (enable && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign expire = (count == '0);

endmodule

// File: rtl/si_stats_window_ctrl.sv
// Window controller for the statistics counters: paces latch/clear pulses,
// tracks pending snapshots and counts snapshots lost before acceptance.
module si_stats_window_ctrl
   import si_stats_window_ctrl_pkg::*;
#(
   parameter int unsigned ETH_CLK_FREQ = 156250000
) (
   input  logic             eth_clk,
   input  logic             eth_rst,
   input  logic [WIN_W-1:0] cfg_window_len,
   input  logic             cmd_start,
   input  logic             cmd_stop,
   input  logic             cmd_clear,
   input  logic             snap_ready,
   output logic             count_en,
   output logic             latch_o,
   output logic             clear_o,
   output logic             snap_valid,
   output logic [SEQ_W-1:0] snap_seq,
   output logic [OVR_W-1:0] overrun_cnt,
   output logic             busy
);

   state_t state;
   state_t state_next;
   logic   latch_next;
   logic   clear_next;
   logic   timer_load;
   logic   timer_expire;

   si_stats_window_timer #(
      .RESET_VALUE(WIN_W'(ETH_CLK_FREQ - 1))
   ) u_timer (
      .eth_clk (eth_clk),
      .eth_rst (eth_rst),
      .load    (timer_load),
      .enable  (state == RUN),
      .value   (window_reload(cfg_window_len)),
      .expire  (timer_expire)
   );

   // Clear outranks stop, stop outranks expiry, so a coinciding stop and
   // expiry yield exactly one latch and no clear.
   always_comb begin
      state_next = state;
      latch_next = 1'b0;
      clear_next = 1'b0;
      timer_load = 1'b0;
      case (state)
         IDLE: begin
            if (!cmd_clear && cmd_start) begin
               state_next = RUN;
               clear_next = 1'b1;
               timer_load = 1'b1;
            end
         end
         RUN: begin
            if (cmd_clear) begin
               clear_next = 1'b1;
               timer_load = 1'b1;
            end else if (cmd_stop) begin
               state_next = FLUSH;
               latch_next = 1'b1;
            end else if (timer_expire) begin
               latch_next = 1'b1;
               clear_next = 1'b1;
               timer_load = 1'b1;
            end
         end
         FLUSH: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge eth_clk) begin
      if (eth_rst) begin
         state    <= IDLE;
         count_en <= 1'b0;
         latch_o  <= 1'b0;
         clear_o  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_next;
         count_en <= (state_next == RUN);
         latch_o  <= latch_next;
         clear_o  <= clear_next;
         busy     <= (state_next != IDLE);
      end
   end

   // Snapshot bookkeeping follows the registered latch pulse by one cycle.
   always_ff @(posedge eth_clk) begin
      if (eth_rst) begin
         snap_valid  <= 1'b0;
         snap_seq    <= '0;
         overrun_cnt <= '0;
      end else begin
         if (latch_o) begin
            snap_valid <= 1'b1;
            snap_seq   <= snap_seq + 1'b1;
         end else if (snap_valid && snap_ready) begin
            snap_valid <= 1'b0;
         end
         if (cmd_clear) begin
            overrun_cnt <= '0;
         end else if (latch_o && snap_valid && !snap_ready && (overrun_cnt != '1)) begin
            overrun_cnt <= overrun_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_si_stats_window_ctrl.sv
// Directed bench for si_stats_window_ctrl: expected latch cycles and sequence
// numbers are queued as commands are driven and matched as latches appear.
module tb_si_stats_window_ctrl;

   logic        eth_clk = 1'b0;
   logic        eth_rst;
   logic [31:0] cfg_window_len;
   logic        cmd_start;
   logic        cmd_stop;
   logic        cmd_clear;
   logic        snap_ready;
   logic        count_en;
   logic        latch_o;
   logic        clear_o;
   logic        snap_valid;
   logic [7:0]  snap_seq;
   logic [15:0] overrun_cnt;
   logic        busy;

   typedef struct {
      int cyc;
      int seq;
   } latch_exp_t;

   latch_exp_t exp_q[$];
   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int pend_seq = 0;
   bit pend = 1'b0;
   int s;

   si_stats_window_ctrl dut (
      .eth_clk        (eth_clk),
      .eth_rst        (eth_rst),
      .cfg_window_len (cfg_window_len),
      .cmd_start      (cmd_start),
      .cmd_stop       (cmd_stop),
      .cmd_clear      (cmd_clear),
      .snap_ready     (snap_ready),
      .count_en       (count_en),
      .latch_o        (latch_o),
      .clear_o        (clear_o),
      .snap_valid     (snap_valid),
      .snap_seq       (snap_seq),
      .overrun_cnt    (overrun_cnt),
      .busy           (busy)
   );

   always #5 eth_clk = ~eth_clk;

   always @(posedge eth_clk) cyc <= cyc + 1;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("[TB] FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
         $error("[TB] check %s did not hold", tag);
      end
   endtask

   task automatic tick();
      @(posedge eth_clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic push_latch(input int c, input int seq);
      latch_exp_t e;
      e.cyc = c;
      e.seq = seq;
      exp_q.push_back(e);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, "_count_en"}, 32'(count_en), 0);
      check_output({tag, "_latch_o"}, 32'(latch_o), 0);
      check_output({tag, "_clear_o"}, 32'(clear_o), 0);
      check_output({tag, "_snap_valid"}, 32'(snap_valid), 0);
      check_output({tag, "_busy"}, 32'(busy), 0);
      check_output({tag, "_snap_seq"}, 32'(snap_seq), 0);
      check_output({tag, "_overrun"}, 32'(overrun_cnt), 0);
   endtask

   // Every latch pulse must match the head of the queue; the sequence number
   // it carries is checked on the following cycle.
   always @(negedge eth_clk) begin
      latch_exp_t e;
      if (pend) begin
         check_output("snap_seq_after_latch", 32'(snap_seq), 32'(pend_seq));
         pend = 1'b0;
      end
      if (latch_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_output("latch_unexpected", 32'(cyc), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check_output("latch_cycle", 32'(cyc), 32'(e.cyc));
            pend_seq = e.seq;
            pend = 1'b1;
         end
      end
   end

   initial begin
      eth_rst        = 1'b1;
      cfg_window_len = 32'd4;
      cmd_start      = 1'b0;
      cmd_stop       = 1'b0;
      cmd_clear      = 1'b0;
      snap_ready     = 1'b0;
      tick();
      tick();
      tick();
      check_reset_outputs("reset");
      eth_rst = 1'b0;
      tick();
      tick();

      // Basic windowing, overrun accumulation and sequence wrap, L=4.
      s = cyc;
      for (int k = 1; k <= 300; k++) push_latch(s + 1 + 4 * k, k % 256);
      cmd_start = 1'b1;
      tick();
      cmd_start = 1'b0;
      check_output("start_clear_o", 32'(clear_o), 1);
      check_output("start_count_en", 32'(count_en), 1);
      check_output("start_busy", 32'(busy), 1);
      check_output("start_latch_o", 32'(latch_o), 0);
      tick();
      check_output("clear_pulse_width", 32'(clear_o), 0);
      wait_until(s + 14);
      check_output("overrun_3win", 32'(overrun_cnt), 2);
      check_output("valid_held", 32'(snap_valid), 1);
      wait_until(s + 1202);
      check_output("seq_wrap", 32'(snap_seq), 44);
      check_output("overrun_300win", 32'(overrun_cnt), 299);
      push_latch(s + 1203, 45);
      cmd_stop = 1'b1;
      tick();
      cmd_stop = 1'b0;
      check_output("flush_count_en", 32'(count_en), 0);
      check_output("flush_clear_o", 32'(clear_o), 0);
      check_output("flush_busy", 32'(busy), 1);
      tick();
      check_output("idle_busy", 32'(busy), 0);
      check_output("idle_latch_o", 32'(latch_o), 0);
      check_output("overrun_flush", 32'(overrun_cnt), 300);

      // Clear in IDLE zeroes overruns; ready drains the pending snapshot.
      cmd_clear  = 1'b1;
      snap_ready = 1'b1;
      tick();
      cmd_clear = 1'b0;
      check_output("idle_clear_overrun", 32'(overrun_cnt), 0);
      check_output("idle_clear_valid", 32'(snap_valid), 0);
      check_output("idle_clear_busy", 32'(busy), 0);
      check_output("idle_clear_clear_o", 32'(clear_o), 0);

      // Stop three cycles after start.
      s = cyc;
      cmd_start = 1'b1;
      tick();
      cmd_start = 1'b0;
      wait_until(s + 3);
      push_latch(s + 4, 46);
      cmd_stop = 1'b1;
      tick();
      cmd_stop = 1'b0;
      check_output("stop_latch_o", 32'(latch_o), 1);
      check_output("stop_count_en", 32'(count_en), 0);
      check_output("stop_clear_o", 32'(clear_o), 0);
      check_output("stop_busy", 32'(busy), 1);
      tick();
      check_output("stop_idle_busy", 32'(busy), 0);
      check_output("stop_idle_latch", 32'(latch_o), 0);
      check_output("stop_snap_valid", 32'(snap_valid), 1);
      tick();
      check_output("stop_valid_drained", 32'(snap_valid), 0);

      // Stop with clear, latch with ready, stop on expiry.
      snap_ready = 1'b0;
      s = cyc;
      push_latch(s + 5, 47);
      push_latch(s + 9, 48);
      push_latch(s + 15, 49);
      push_latch(s + 19, 50);
      cmd_start = 1'b1;
      tick();
      cmd_start = 1'b0;
      wait_until(s + 10);
      check_output("overrun_before_clear", 32'(overrun_cnt), 1);
      cmd_stop  = 1'b1;
      cmd_clear = 1'b1;
      tick();
      cmd_stop  = 1'b0;
      cmd_clear = 1'b0;
      check_output("stopclr_clear_o", 32'(clear_o), 1);
      check_output("stopclr_latch_o", 32'(latch_o), 0);
      check_output("stopclr_busy", 32'(busy), 1);
      check_output("stopclr_count_en", 32'(count_en), 1);
      check_output("stopclr_overrun", 32'(overrun_cnt), 0);
      wait_until(s + 15);
      snap_ready = 1'b1;
      tick();
      check_output("latch_ready_valid", 32'(snap_valid), 1);
      check_output("latch_ready_overrun", 32'(overrun_cnt), 0);
      wait_until(s + 18);
      cmd_stop = 1'b1;
      tick();
      cmd_stop = 1'b0;
      check_output("stopexp_clear_o", 32'(clear_o), 0);
      check_output("stopexp_count_en", 32'(count_en), 0);
      check_output("stopexp_busy", 32'(busy), 1);
      tick();
      check_output("stopexp_idle_latch", 32'(latch_o), 0);
      check_output("stopexp_idle_busy", 32'(busy), 0);

      // Zero length gives a latch every cycle; reset abandons the window.
      cfg_window_len = 32'd0;
      s = cyc;
      for (int k = 2; k <= 5; k++) push_latch(s + k, 49 + k);
      push_latch(s + 6, 0);
      cmd_start = 1'b1;
      tick();
      cmd_start = 1'b0;
      check_output("zero_len_clear_o", 32'(clear_o), 1);
      wait_until(s + 6);
      check_output("zero_len_latch_o", 32'(latch_o), 1);
      check_output("zero_len_clear_with_latch", 32'(clear_o), 1);
      eth_rst   = 1'b1;
      cmd_start = 1'b1;
      tick();
      check_reset_outputs("midwin_reset");
      tick();
      check_output("reset_ignores_start", 32'(busy), 0);
      eth_rst   = 1'b0;
      cmd_start = 1'b0;
      tick();
      check_output("post_reset_busy", 32'(busy), 0);
      check_output("post_reset_count_en", 32'(count_en), 0);
      tick();

      check_output("latch_queue_empty", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/si_stats_window_ctrl.md
SI_STATS_WINDOW_CTRL -- requirements
Module: si_stats_window_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named eth_clk and eth_rst.
REQ-002 Parameter ETH_CLK_FREQ, default 156250000, SHALL be the window length loaded at reset.
REQ-003 eth_clk  in  1  sole clock for all logic.
REQ-004 eth_rst  in  1  synchronous active-high reset.
REQ-005 cfg_window_len  in  32  window length in eth_clk cycles; 0 SHALL be treated as 1.
REQ-006 cmd_start  in  1  single-cycle pulse that starts windowed counting.
REQ-007 cmd_stop  in  1  single-cycle pulse that stops counting after a final partial-window snapshot.
REQ-008 cmd_clear  in  1  single-cycle pulse that restarts the current window and clears overrun_cnt.
REQ-009 snap_ready  in  1  consumer accepts the pending snapshot.
REQ-010 count_en  out  1  gate for the statistics counters.
REQ-011 latch_o  out  1  one-cycle pulse telling the counters to capture their rate values.
REQ-012 clear_o  out  1  one-cycle pulse telling the counters to zero their rate values.
REQ-013 snap_valid  out  1  a latched snapshot is pending.
REQ-014 snap_seq  out  8  sequence number of the latest snapshot.
REQ-015 overrun_cnt  out  16  count of snapshots overwritten before they were accepted.
REQ-016 busy  out  1  high when the state is not IDLE.

Function
REQ-017 The state machine SHALL have three states: IDLE, RUN and FLUSH.
REQ-018 Command priority SHALL be cmd_clear > cmd_stop > cmd_start when commands arrive in the same cycle.
REQ-019 In IDLE, cmd_start at cycle N SHALL cause the following, all at cycle N+1:
- RUN is entered;
- count_en=1;
- clear_o pulses;
- the timer is loaded with max(cfg_window_len,1)-1.
REQ-020 cfg_window_len SHALL be sampled only on timer load (start, clear, expiry); a change mid-window SHALL take effect at the next load.
REQ-021 In RUN, the timer SHALL decrement each cycle; when the timer is 0, latch_o and clear_o SHALL pulse together and the timer SHALL reload.
- Consequence: boundaries fall at N+L, N+2L, ... where L is the window length.
REQ-022 In RUN, cmd_stop SHALL do the following:
- FLUSH is entered on the next cycle, with latch_o=1, clear_o=0 and count_en=0 in that cycle;
- IDLE is entered on the cycle after that.
REQ-023 If cmd_stop coincides with timer expiry, only one latch_o SHALL be issued.
REQ-024 In RUN, cmd_start SHALL be ignored; in IDLE and FLUSH, cmd_stop SHALL be ignored; in FLUSH, cmd_start SHALL be ignored.
REQ-025 cmd_clear SHALL have the following effects:
- always: overrun_cnt is zeroed;
- in RUN: clear_o pulses on the next cycle, the timer reloads, and no latch_o is issued;
- in IDLE or FLUSH: no other effect.
REQ-026 Each latch_o SHALL have these effects on the next cycle:
- snap_seq is incremented (wrapping 255->0);
- snap_valid is set.
REQ-027 snap_valid SHALL remain high until a cycle with snap_valid & snap_ready & no new latch_o, and SHALL clear on the following cycle.
REQ-028 When latch_o occurs while snap_valid=1 & snap_ready=0, overrun_cnt SHALL increment, saturating at 16'hFFFF.
REQ-029 When latch_o coincides with snap_ready=1, snap_valid SHALL stay 1 and no overrun SHALL be counted.
REQ-030 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-031 While eth_rst=1, the following SHALL hold at the next edge:
- state=IDLE;
- count_en=0, latch_o=0, clear_o=0, snap_valid=0, busy=0;
- snap_seq=0, overrun_cnt=0;
- timer=ETH_CLK_FREQ-1.
REQ-032 Reset asserted mid-window or in FLUSH SHALL abandon the window and emit no latch_o.
REQ-033 Commands SHALL be ignored while eth_rst=1.

Structure
REQ-034 A shared statistics package SHALL hold the state enum (IDLE/RUN/FLUSH) and the width constants SEQ_W=8 and OVR_W=16.
REQ-035 A sub-module si_stats_window_timer SHALL implement the loadable down-counter, with load, value and expire ports.
REQ-036 The block SHALL contain no clock-domain crossing; the wishbone-side crossing remains in the statistics module.

Verification
REQ-037 Basic windowing: reset; cfg_window_len=4; cmd_start at cycle 10 -> clear_o at 11; latch_o at 15, 19, 23; snap_seq=1 at 16.
REQ-038 Overrun and wrap: cfg_window_len=4, snap_ready=0, run 3 windows -> overrun_cnt=2 and snap_valid held; with snap_ready=0 for 300 windows -> snap_seq wraps to 44 and overrun_cnt=299.
REQ-039 Stop and flush: cmd_stop at cycle 13 with L=4 from start at 10 -> FLUSH at 14 with latch_o=1 and count_en=0; IDLE at 15; no latch_o at 15.
REQ-040 Simultaneous events:
- cmd_stop and cmd_clear in the same cycle -> clear wins, state stays RUN, overrun_cnt=0;
- latch_o together with snap_ready=1 -> snap_valid stays 1, overrun_cnt unchanged.
REQ-041 Zero length and mid-window reset: cfg_window_len=0 -> latch_o every cycle; eth_rst asserted mid-window -> all outputs at reset values on the next cycle and no latch_o.
